// File: rtl/mux_8_to_1.sv
// Registered 8-to-1 single-bit mux in gate-level form: one-hot select decode,
// AND gating, OR tree, reset gating, and a single output flop.
module mux_8_to_1 (
    input  logic       clk,
    input  logic       rst,
    output logic       Y,
    input  logic [7:0] I,
    input  logic       S2,
    input  logic       S1,
    input  logic       S0
);

    localparam int unsigned N_IN = 8;

    logic            s2_n;
    logic            s1_n;
    logic            s0_n;
    logic            rst_n_gate;
    logic [N_IN-1:0] minterm;
    logic [N_IN-1:0] gated;
    logic [3:0]      or_l1;
    logic [1:0]      or_l2;
    logic            sel;
    logic            next_bit;

    // Select-line inverters
    assign s2_n = ~S2;
    assign s1_n = ~S1;
    assign s0_n = ~S0;

    // One-hot minterm decode: minterm[k] is high iff {S2,S1,S0} == k
    assign minterm[0] = s2_n & s1_n & s0_n;
    assign minterm[1] = s2_n & s1_n & S0;
    assign minterm[2] = s2_n & S1   & s0_n;
    assign minterm[3] = s2_n & S1   & S0;
    assign minterm[4] = S2   & s1_n & s0_n;
    assign minterm[5] = S2   & s1_n & S0;
    assign minterm[6] = S2   & S1   & s0_n;
    assign minterm[7] = S2   & S1   & S0;

    // Data gating
    assign gated[0] = minterm[0] & I[0];
    assign gated[1] = minterm[1] & I[1];
    assign gated[2] = minterm[2] & I[2];
    assign gated[3] = minterm[3] & I[3];
    assign gated[4] = minterm[4] & I[4];
    assign gated[5] = minterm[5] & I[5];
    assign gated[6] = minterm[6] & I[6];
    assign gated[7] = minterm[7] & I[7];

    // Balanced OR tree
    assign or_l1[0] = gated[0] | gated[1];
    assign or_l1[1] = gated[2] | gated[3];
    assign or_l1[2] = gated[4] | gated[5];
    assign or_l1[3] = gated[6] | gated[7];
    assign or_l2[0] = or_l1[0] | or_l1[1];
    assign or_l2[1] = or_l1[2] | or_l1[3];
    assign sel      = or_l2[0] | or_l2[1];

    // Synchronous reset folded into the D input as a gate
    assign rst_n_gate = ~rst;
    assign next_bit   = sel & rst_n_gate;

    always_ff @(posedge clk) begin
        Y <= next_bit;
    end

endmodule

// File: tb/tb_mux_8_to_1.sv
// Self-checking bench for mux_8_to_1: directed scenarios plus randomized
// stimulus against a one-line behavioural model of the registered mux.
module tb_mux_8_to_1;

    logic       clk;
    logic       rst;
    logic       Y;
    logic [7:0] I;
    logic       S2;
    logic       S1;
    logic       S0;

    int n_checks = 0;
    int n_fail   = 0;

    mux_8_to_1 dut (
        .clk (clk),
        .rst (rst),
        .Y   (Y),
        .I   (I),
        .S2  (S2),
        .S1  (S1),
        .S0  (S0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value Y must hold after an edge that sampled these inputs
    function automatic logic model_y(input logic [7:0] i, input logic [2:0] s, input logic r);
        int idx;
        idx = int'(s);
        return r ? 1'b0 : i[idx];
    endfunction

    task automatic drive(input logic [7:0] i, input logic [2:0] s, input logic r);
        I  = i;
        {S2, S1, S0} = s;
        rst = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(8'hFF, 3'b111, 1'b1);
        for (int n = 0; n < 2; n++) begin
            tick();
            n_checks++;
            if (Y !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold edge%0d: Y=%b required 0", n, Y);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (Y !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: Y=%b required 1", Y);
        end
    endtask

    // Sweep with a one-edge reset pulse injected at code 4 once Y is already 1
    task automatic test_select_sweep();
        logic [7:0] pattern;
        logic [7:0] exp_seq;
        logic       exp;
        logic       r;
        pattern = 8'b10011100;
        exp_seq = 8'b10011100;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                r = (k == 4 && c == 2);
                drive(pattern, 3'(k), r);
                tick();
                exp = r ? 1'b0 : exp_seq[k];
                n_checks++;
                if (Y !== exp) begin
                    n_fail++;
                    $display("FAIL sweep s=%0d cyc=%0d rst=%b: Y=%b required %b", k, c, r, Y, exp);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_walking();
        logic [7:0] onehot;
        logic       exp;
        for (int inv = 0; inv < 2; inv++) begin
            for (int k = 0; k < 8; k++) begin
                for (int j = 0; j < 8; j++) begin
                    onehot = 8'h01 << j;
                    if (inv == 1) onehot = ~onehot;
                    drive(onehot, 3'(k), 1'b0);
                    tick();
                    exp = (inv == 0) ? (j == k) : (j != k);
                    n_checks++;
                    if (Y !== exp) begin
                        n_fail++;
                        $display("FAIL walk inv=%0d s=%0d j=%0d: Y=%b required %b", inv, k, j, Y, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_latency();
        logic prev_bit;
        logic [7:0] val;
        drive(8'h00, 3'b010, 1'b0);
        tick();
        prev_bit = 1'b0;
        for (int n = 0; n < 16; n++) begin
            val = (n % 2 == 0) ? 8'h04 : 8'h00;
            I = val;
            n_checks++;
            if (Y !== prev_bit) begin
                n_fail++;
                $display("FAIL latency_pre n=%0d: Y=%b required %b", n, Y, prev_bit);
            end
            tick();
            prev_bit = val[2];
            n_checks++;
            if (Y !== prev_bit) begin
                n_fail++;
                $display("FAIL latency_post n=%0d: Y=%b required %b", n, Y, prev_bit);
            end
        end
        // Pulses that vanish before the edge must never reach Y
        I = 8'h00;
        tick();
        for (int n = 0; n < 4; n++) begin
            #2 I = 8'h04;
            #2 I = 8'h00;
            tick();
            n_checks++;
            if (Y !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_pulse n=%0d: Y=%b required 0", n, Y);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] i;
        logic [2:0] s;
        logic       r;
        logic       exp;
        int         errs;
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            i = 8'($urandom);
            s = 3'($urandom);
            r = ($urandom_range(0, 99) < 5);
            drive(i, s, r);
            tick();
            exp = model_y(i, s, r);
            n_checks++;
            if (Y !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random n=%0d i=%h s=%0d rst=%b: Y=%b required %b", n, i, s, r, Y, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(8'h00, 3'b000, 1'b1);
        @(negedge clk);
        test_reset();
        test_select_sweep();
        test_walking();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_8_to_1.md
# mux_8_to_1

Registered 8-to-1 single-bit multiplexer built in structural (gate-level) style. One of eight data bits `I[7:0]` is chosen by the three select lines `S2 S1 S0` (S2 = MSB) and presented on `Y` through one output flip-flop. It serves as a leaf selection primitive in datapaths and as a reference block for gate-level mux construction.

## Interface
- Parameters: none; data width fixed at 8 inputs × 1 bit.
- `clk`  input  1  rising-edge clock; only clock in the block.
- `rst`  input  1  reset, synchronous and active-high; sampled on rising `clk`.
- `Y`    output 1  registered selected data bit.
- `I`    input  8  data inputs; `I[k]` selected when `{S2,S1,S0}` = k.
- `S2`   input  1  select bit 2 (MSB).
- `S1`   input  1  select bit 1.
- `S0`   input  1  select bit 0 (LSB).
- Port order after `clk, rst`: `Y, I, S2, S1, S0`.

## Operation
- Select decode: inverters on S2/S1/S0 plus eight 3-input AND gates produce one-hot minterms m0..m7; mk = 1 iff `{S2,S1,S0}` = k.
- Data gating: eight 2-input ANDs, dk = mk & I[k].
- Combine: OR tree of d0..d7 gives combinational `sel` = I[{S2,S1,S0}].
- Reset gating: next = sel & ~rst, built from gates, not a behavioural if/else.
- Output register: single D flip-flop, D = next, Q = `Y`.
- All eight select codes legal; no invalid or idle code.
- Data and select inputs unconstrained; any change before a clock edge is picked up at that edge.
- No enable, no handshake, no internal state other than the output flop.

## Timing
- Latency: 1 clock. `Y` after rising edge n equals I[{S2,S1,S0}] as sampled at edge n.
- Inputs are sampled only at the rising `clk`. Changes between edges do not reach `Y` until the next edge. `Y` never glitches between edges.
- Reset: `rst` = 1 at a rising edge forces `Y` = 0 after that edge, regardless of I and S.
- Reset value: `Y` = 0. Before the first edge with `rst` asserted, `Y` is undefined.
- Reset mid-operation: reset has priority over data for every edge at which it is high. On the first edge with `rst` = 0, `Y` loads the currently selected bit. No extra recovery cycle.
- Simultaneous change of select and data before an edge: `Y` takes the new data bit at the new select code.
- Combinational decode/OR path must close within one clock period. No multicycle paths.

## Test plan
- Reset: hold `rst` = 1 for 2 edges with I = 8'hFF, S = 3'b111 → `Y` = 0 after each edge. Release → next edge `Y` = 1.
- Select sweep: I = 8'b10011100, step `{S2,S1,S0}` 000→111, one code per 4 clocks. `Y` one edge after each step = 0,0,1,1,1,0,0,1.
- Walking one: S fixed at k = 0..7. I = one-hot bit j for all j → `Y` = 1 only when j = k, else 0. Repeat with walking zero (inverse I) → `Y` = 0 only when j = k.
- Latency check: S = 3'b010, I toggles 8'h00 ↔ 8'h04 every edge → `Y` follows I[2] exactly one edge late. Mid-cycle I pulses that are gone before the edge never appear on `Y`.
- Reset mid-stream: during the select sweep, assert `rst` for 1 edge at S = 3'b100 (Y was 1) → `Y` = 0 for that cycle. Next edge `Y` = 1 again.
- Randomized: 1000 cycles of random I, S, `rst` (5% high) against the model Y_next = rst ? 0 : I[S]. Zero mismatches.
